// File: rtl/match_window_monitor.sv
// match_window_monitor: splits the valid sample stream into WINDOW-sample windows,
// reports the match-count delta of each completed window through a one-entry
// valid/ready buffer, flags high-rate windows and counts results lost to back-pressure.
module match_window_monitor #(
   parameter int unsigned WINDOW = 16,  // valid samples per window (2..255)
   parameter int unsigned THRESH = 8    // rate_high when delta >= THRESH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [15:0] match_count_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] window_matches,
   output logic [7:0]  window_id,
   output logic        rate_high,
   output logic [7:0]  drop_count
);

   localparam logic StInit = 1'b0;
   localparam logic StRun  = 1'b1;

   localparam logic [7:0]  LastSc   = 8'(WINDOW - 1);
   localparam logic [15:0] ThreshV  = 16'(THRESH);

   logic        state_q, state_d;
   logic [15:0] baseline_q, baseline_d;
   logic [7:0]  sc_q, sc_d;
   logic [7:0]  completion_id_q, completion_id_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] window_matches_q, window_matches_d;
   logic [7:0]  window_id_q, window_id_d;
   logic        rate_high_q, rate_high_d;
   logic [7:0]  drop_count_q, drop_count_d;

   logic        complete;
   logic        transfer;
   logic [15:0] delta;

   // Window completion, modular delta and buffer handshake decode
   always_comb begin
      complete = valid_in && (state_q == StRun) && (sc_q == LastSc);
      transfer = out_valid_q && out_ready;
      // Modular subtraction keeps the count correct across a 65535->0 wrap
      delta    = match_count_in - baseline_q;
   end

   // Sampling state machine: baseline capture and per-window sample counting
   always_comb begin
      state_d         = state_q;
      baseline_d      = baseline_q;
      sc_d            = sc_q;
      completion_id_d = completion_id_q;
      if (valid_in) begin
         if (state_q == StInit) begin
            baseline_d = match_count_in;
            sc_d       = 8'd0;
            state_d    = StRun;
         end else if (complete) begin
            baseline_d      = match_count_in;
            sc_d            = 8'd0;
            completion_id_d = completion_id_q + 8'd1;
         end else begin
            sc_d = sc_q + 8'd1;
         end
      end
   end

   // One-entry result buffer: load when empty or draining, otherwise drop
   always_comb begin
      out_valid_d      = out_valid_q;
      window_matches_d = window_matches_q;
      window_id_d      = window_id_q;
      rate_high_d      = rate_high_q;
      drop_count_d     = drop_count_q;
      if (complete && (!out_valid_q || out_ready)) begin
         out_valid_d      = 1'b1;
         window_matches_d = delta;
         window_id_d      = completion_id_q;
         rate_high_d      = (delta >= ThreshV);
      end else if (complete) begin
         if (drop_count_q != 8'hff) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end else if (transfer) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StInit;
         baseline_q       <= 16'd0;
         sc_q             <= 8'd0;
         completion_id_q  <= 8'd0;
         out_valid_q      <= 1'b0;
         window_matches_q <= 16'd0;
         window_id_q      <= 8'd0;
         rate_high_q      <= 1'b0;
         drop_count_q     <= 8'd0;
      end else begin
         state_q          <= state_d;
         baseline_q       <= baseline_d;
         sc_q             <= sc_d;
         completion_id_q  <= completion_id_d;
         out_valid_q      <= out_valid_d;
         window_matches_q <= window_matches_d;
         window_id_q      <= window_id_d;
         rate_high_q      <= rate_high_d;
         drop_count_q     <= drop_count_d;
      end
   end

   // Drive outputs straight from the buffer registers
   always_comb begin
      out_valid      = out_valid_q;
      window_matches = window_matches_q;
      window_id      = window_id_q;
      rate_high      = rate_high_q;
      drop_count     = drop_count_q;
   end

endmodule

// File: doc/match_window_monitor.md
Name: match_window_monitor

Overview:
- Downstream consumer of the pipelined processing unit's `valid_out`/`match_count` stream.
- Splits the valid samples into fixed-size windows and computes the number of new matches in each window, with wrap-safe 16-bit arithmetic.
- Flags high-rate windows and presents each result to a display/logging consumer through a one-entry valid/ready output buffer.
- Counts windows lost to back-pressure.

Parameters:
- WINDOW, 16, valid samples per window (2..255).
- THRESH, 8, rate_high asserted when window delta >= THRESH (0..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- valid_in  input  1  sample strobe; driven by upstream `valid_out`.
- match_count_in  input  16  running match counter; driven by upstream `match_count`.
- out_valid  output  1  result buffer holds an unread result.
- out_ready  input  1  consumer accepts the result this cycle.
- window_matches  output  16  matches counted in the completed window.
- window_id  output  8  index of the completed window; wraps 255->0.
- rate_high  output  1  window_matches >= THRESH.
- drop_count  output  8  windows discarded because the buffer was full; saturates at 255.

Behaviour:
- Reset: synchronous, clk edge with rst=1.
  - out_valid=0, window_matches=0, window_id=0, rate_high=0, drop_count=0.
  - Internal baseline=0, sample count sc=0, state=INIT.
  - rst mid-window or with a result pending discards all data; the pending result is not delivered.
- States:
  - INIT: waiting for the baseline sample. On valid_in: baseline<=match_count_in, sc<=0, go RUN. No result is produced.
  - RUN: on each valid_in, sc<=sc+1.
  - Window completes on the valid_in with sc==WINDOW-1, i.e. the WINDOW-th sample after the baseline.
  - On completion: delta=(match_count_in-baseline) mod 2^16; baseline<=match_count_in; sc<=0; stay in RUN.
  - Cycles with valid_in=0 change nothing except the output handshake.
- Arithmetic:
  - delta is a 16-bit modular subtraction, so wrap of match_count_in (65535->0) yields the correct count.
  - rate_high is computed from delta with an unsigned 16-bit compare.
- Completion ID: completion_id starts at 0 after reset and increments (mod 256) on every completed window, delivered or dropped. Gaps in delivered window_id therefore reveal drops.
- Output buffer (one entry):
  - Handshake: transfer occurs when out_valid & out_ready. Data is stable while out_valid=1 and out_ready=0.
  - Completion, buffer empty or draining this cycle: next cycle out_valid=1, window_matches=delta, rate_high=(delta>=THRESH), window_id=completion_id.
  - Simultaneous completion and transfer: the new result replaces the old one and out_valid stays 1. No drop.
  - Completion, buffer full and not draining: the result is discarded, the buffer is unchanged, and drop_count increments (saturating at 255). completion_id still increments.
  - Transfer with no completion: out_valid<=0 next cycle. The data registers hold their last values.
- Latency: result visible one cycle after the completing valid_in edge.
- out_ready while out_valid=0 is ignored.

Test Plan:
1. WINDOW=4, THRESH=3, out_ready=1:
   - Stimulus: rst 2 cycles, then valid_in pulses with match_count_in 10 (baseline), 11, 12, 12, 14.
   - Response: one cycle after the 14 sample, out_valid=1, window_matches=4, rate_high=1, window_id=0. out_valid=0 on the following cycle.
2. Wrap-around:
   - Stimulus: baseline 65534, samples 65535, 0, 0, 1.
   - Response: window_matches=3, rate_high=1. A second window with samples 1,1,1,1 gives window_matches=0, rate_high=0, window_id=1.
3. Back-pressure:
   - Stimulus: out_ready=0; complete three windows.
   - Response: first result held stable with window_id=0; drop_count=2. Raise out_ready: one transfer, out_valid=0. The next completion delivers window_id=3.
4. Simultaneous event:
   - Stimulus: buffer full; completion on the same edge as out_valid&out_ready.
   - Response: new result loaded, out_valid stays 1, drop_count unchanged.
5. Reset mid-operation:
   - Stimulus: rst asserted with sc=2 and a pending result.
   - Response: out_valid=0, drop_count=0, window_id=0. The next valid_in is taken as the baseline and produces no output.
6. Gapped strobes:
   - Stimulus: valid_in asserted on alternate cycles at default WINDOW=16.
   - Response: a result appears only after 16 post-baseline samples. Intermediate idle cycles leave sc unchanged.
